deinterleaver: RTL and testbench

DEINTERLEAVER -- requirements
Module: deinterleaver

---
 rtl/deinterleaver.sv | 150 +++++++++++++++
 tb/tb_deinterleaver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver.sv
// Block deinterleaver: serial column-major frames in, row-major frames out, ping-pong bit store.
// Define DEINT_SYNC_EN to add frame sync (din_sof input, sync_err output).
module deinterleaver #(
  parameter int unsigned LOG2_DIM = 3
) (
  input  logic clk2,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
`ifdef DEINT_SYNC_EN
  input  logic din_sof,
  output logic sync_err,
`endif
  output logic dout,
  output logic dout_valid,
  output logic dout_last
);

  localparam int unsigned L  = LOG2_DIM;
  localparam int unsigned CW = 2 * L;
  localparam int unsigned F  = 1 << CW;
  localparam logic [CW-1:0] LastCnt = CW'(F - 1);

  typedef enum logic {StIdle, StRead} state_e;

  logic [2*F-1:0] mem_q;
  logic [CW-1:0]  wr_cnt_q;
  logic [CW-1:0]  wr_k;
  logic           wr_bank_q;
  logic [CW:0]    wr_addr;
  logic           accept;
  logic           resync;
  logic           frame_done;

  state_e         state_q;
  logic [CW-1:0]  rd_cnt_q;
  logic           rd_bank_q;
  logic [CW:0]    rd_addr;
  logic           rd_last;
  logic           pend_q;
  logic           pend_bank_q;
  logic           dout_q;
  logic           dout_valid_q;
  logic           dout_last_q;

`ifdef DEINT_SYNC_EN
  logic synced_q;
  logic sync_err_q;

  // Bits are dropped until the first marked start-of-frame after reset.
  assign accept = din_valid & (synced_q | din_sof);
  assign resync = din_valid & din_sof & synced_q & (wr_cnt_q != '0);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      synced_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (din_valid & din_sof) begin
        synced_q <= 1'b1;
      end
      sync_err_q <= resync;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign accept = din_valid;
  assign resync = 1'b0;
`endif

  // A resync restarts the frame in the current bank at bit 0.
  assign wr_k       = resync ? '0 : wr_cnt_q;
  assign frame_done = accept & ~resync & (wr_cnt_q == LastCnt);
  assign wr_addr    = {wr_bank_q, wr_k[L-1:0], wr_k[CW-1:L]};

  always_ff @(posedge clk2) begin
    if (accept) begin
      mem_q[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (accept) begin
      if (frame_done) begin
        wr_cnt_q  <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else begin
        wr_cnt_q <= wr_k + 1'b1;
      end
    end
  end

  assign rd_addr = {rd_bank_q, rd_cnt_q};
  assign rd_last = (rd_cnt_q == LastCnt);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_bank_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_done) begin
            state_q   <= StRead;
            rd_cnt_q  <= '0;
            rd_bank_q <= wr_bank_q;
          end
        end
        StRead: begin
          dout_q       <= mem_q[rd_addr];
          dout_valid_q <= 1'b1;
          dout_last_q  <= rd_last;
          rd_cnt_q     <= rd_cnt_q + 1'b1;
          if (rd_last) begin
            // A bank completing on the last read bit chains with no idle cycle.
            if (frame_done) begin
              rd_bank_q <= wr_bank_q;
            end else if (pend_q) begin
              rd_bank_q <= pend_bank_q;
              pend_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else if (frame_done) begin
            pend_q      <= 1'b1;
            pend_bank_q <= wr_bank_q;
          end
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Bench for deinterleaver: LOG2_DIM=3 and LOG2_DIM=2 instances against a queue-based frame model.
module tb_deinterleaver;

  localparam int MAXC = 8192;
  localparam int CAPN = 512;

  logic       clk2  = 1'b0;
  logic       rst_n = 1'b0;
  // Index 0: LOG2_DIM=3 instance, index 1: LOG2_DIM=2 instance.
  logic [1:0] din   = '0;
  logic [1:0] dv    = '0;
  logic [1:0] sof   = '0;
  logic [1:0] dout;
  logic [1:0] dvo;
  logic [1:0] dlast;
`ifdef DEINT_SYNC_EN
  logic [1:0] serr;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2:0] sched    [2][MAXC];
  logic       serr_exp [2][MAXC];
  bit         part     [2][$];
  bit         synced   [2];

  bit cap [2][CAPN];
  int cap_n [2];
  int cap_first [2];
  int cap_lastc [2];
  int cap_lastidx [2];
  int serr_n = 0;
  int serr_c = -1;

  always #5 clk2 = ~clk2;

  deinterleaver #(.LOG2_DIM(3)) u_dut3 (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .din       (din[0]),
    .din_valid (dv[0]),
`ifdef DEINT_SYNC_EN
    .din_sof   (sof[0]),
    .sync_err  (serr[0]),
`endif
    .dout      (dout[0]),
    .dout_valid(dvo[0]),
    .dout_last (dlast[0])
  );

  deinterleaver #(.LOG2_DIM(2)) u_dut2 (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .din       (din[1]),
    .din_valid (dv[1]),
`ifdef DEINT_SYNC_EN
    .din_sof   (sof[1]),
    .sync_err  (serr[1]),
`endif
    .dout      (dout[1]),
    .dout_valid(dvo[1]),
    .dout_last (dlast[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bit(input string name, input int d, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d]: got %b, expected %b (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Frame model: collect F accepted bits, output bit a is input bit (a%N)*N + a/N.
  function automatic void model_step(input int d, input logic rn, input logic v, input logic b,
                                     input logic s);
    int n = (d == 0) ? 8 : 4;
    int f = n * n;
    if (!rn) begin
      part[d].delete();
      synced[d] = 1'b0;
      for (int c = cyc; c < MAXC; c++) begin
        sched[d][c]    = 3'b000;
        serr_exp[d][c] = 1'b0;
      end
      return;
    end
    if (!v) return;
`ifdef DEINT_SYNC_EN
    if (!synced[d]) begin
      if (!s) return;
      synced[d] = 1'b1;
    end else if (s && part[d].size() != 0) begin
      part[d].delete();
      serr_exp[d][cyc] = 1'b1;
    end
`else
    if (s === 1'bx) return;
`endif
    part[d].push_back(b);
    if (part[d].size() == f) begin
      for (int a = 0; a < f; a++) begin
        if (cyc + 1 + a < MAXC) sched[d][cyc + 1 + a] = {1'b1, a == f - 1, part[d][(a % n) * n + a / n]};
      end
      part[d].delete();
    end
  endfunction

  always @(posedge clk2) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) model_step(d, rst_n, dv[d], din[d], sof[d]);
  end

  always @(negedge clk2) begin
    if (cyc > 0 && cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] e;
        e = rst_n ? sched[d][cyc] : 3'b000;
        chk_bit("dout_valid", d, dvo[d], e[2]);
        chk_bit("dout_last", d, dlast[d], e[1]);
        chk_bit("dout", d, dout[d], e[0]);
`ifdef DEINT_SYNC_EN
        chk_bit("sync_err", d, serr[d], rst_n ? serr_exp[d][cyc] : 1'b0);
        if (d == 0 && serr[0]) begin
          serr_n++;
          serr_c = cyc;
        end
`endif
        if (dvo[d]) begin
          if (cap_n[d] < CAPN) cap[d][cap_n[d]] = dout[d];
          if (cap_n[d] == 0) cap_first[d] = cyc;
          cap_lastc[d] = cyc;
          if (dlast[d]) cap_lastidx[d] = cap_n[d];
          cap_n[d]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_cap(input int d);
    cap_n[d] = 0;
    cap_first[d] = -1;
    cap_lastc[d] = -1;
    cap_lastidx[d] = -1;
    for (int i = 0; i < CAPN; i++) cap[d][i] = 1'b0;
  endtask

  function automatic int ones(input int d, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(cap[d][i]);
    return s;
  endfunction

  // pat 0: only bit k=1 high, 1: all zeros, 2: all ones; sof marks bit 0.
  task automatic send(input int d, input int pat, input bit gap, output int first_c,
                      output int last_c);
    int f = (d == 0) ? 64 : 16;
    first_c = -1;
    for (int k = 0; k < f; k++) begin
      if (gap && k > 0) begin
        dv[d] = 1'b0;
        sof[d] = 1'b0;
        step();
      end
      dv[d]  = 1'b1;
      sof[d] = (k == 0);
      din[d] = (pat == 0) ? (k == 1) : (pat == 2);
      step();
      if (k == 0) first_c = cyc;
    end
    last_c = cyc;
    dv[d]  = 1'b0;
    sof[d] = 1'b0;
    din[d] = 1'b0;
  endtask

  initial begin
    int fc;
    int lc;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < MAXC; c++) begin
        sched[d][c]    = 3'b000;
        serr_exp[d][c] = 1'b0;
      end
      clear_cap(d);
    end

    repeat (3) @(posedge clk2);
    #1;
    chk_bit("reset dout_valid", 0, dvo[0], 1'b0);
    chk_bit("reset dout", 0, dout[0], 1'b0);
    chk_bit("reset dout_last", 0, dlast[0], 1'b0);
    chk_bit("reset dout_valid", 1, dvo[1], 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Single high bit k=1 lands at output position 8.
    clear_cap(0);
    send(0, 0, 1'b0, fc, lc);
    idle(70);
    chk("t1 burst length", cap_n[0], 64);
    chk("t1 first output cycle", cap_first[0], lc + 1);
    chk("t1 ones", ones(0, 0, 63), 1);
    chk("t1 bit8", int'(cap[0][8]), 1);
    chk("t1 last index", cap_lastidx[0], 63);

    // Same frame with a gap cycle between every accepted bit.
    clear_cap(0);
    send(0, 0, 1'b1, fc, lc);
    idle(70);
    chk("t2 burst length", cap_n[0], 64);
    chk("t2 first output cycle", cap_first[0], lc + 1);
    chk("t2 bit8", int'(cap[0][8]), 1);
    chk("t2 ones", ones(0, 0, 63), 1);

    // Three frames back-to-back: 0s, 1s, 0s.
    clear_cap(0);
    send(0, 1, 1'b0, fc, lc);
    send(0, 2, 1'b0, fc, lc);
    send(0, 1, 1'b0, fc, lc);
    idle(70);
    chk("t3 burst length", cap_n[0], 192);
    chk("t3 contiguous span", cap_lastc[0] - cap_first[0] + 1, 192);
    chk("t3 block0 ones", ones(0, 0, 63), 0);
    chk("t3 block1 ones", ones(0, 64, 127), 64);
    chk("t3 block2 ones", ones(0, 128, 191), 0);

    // Reset in the middle of an output burst, right after output bit 20.
    clear_cap(0);
    send(0, 0, 1'b0, fc, lc);
    for (int i = 0; i < 200 && cap_n[0] < 21; i++) begin
      @(negedge clk2);
      #1;
    end
    chk("t4 reached bit 20", cap_n[0], 21);
    rst_n = 1'b0;
    #1;
    chk_bit("t4 async clear dout_valid", 0, dvo[0], 1'b0);
    step();
    rst_n = 1'b1;
    idle(80);
    chk("t4 no output after reset", cap_n[0], 21);
    send(0, 0, 1'b0, fc, lc);
    idle(70);
    chk("t4 new frame length", cap_n[0], 85);
    chk("t4 new frame bit8", int'(cap[0][21 + 8]), 1);

    // Small matrix: k=1 lands at output position 4.
    clear_cap(1);
    send(1, 0, 1'b0, fc, lc);
    idle(30);
    chk("t5 burst length", cap_n[1], 16);
    chk("t5 first output cycle", cap_first[1], lc + 1);
    chk("t5 ones", ones(1, 0, 15), 1);
    chk("t5 bit4", int'(cap[1][4]), 1);
    chk("t5 last index", cap_lastidx[1], 15);

    // Random traffic on both instances, model-checked every cycle.
    for (int i = 0; i < 900; i++) begin
      for (int d = 0; d < 2; d++) begin
        dv[d]  = ($urandom_range(0, 3) != 0);
        din[d] = 1'($urandom);
        sof[d] = ($urandom_range(0, 49) == 0);
      end
      step();
    end
    dv  = '0;
    sof = '0;
    din = '0;
    idle(80);

`ifdef DEINT_SYNC_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(2);
    // Ten bits of a frame, then a new start-of-frame forces a resync.
    for (int k = 0; k < 10; k++) begin
      dv[0]  = 1'b1;
      sof[0] = (k == 0);
      din[0] = 1'($urandom);
      step();
    end
    clear_cap(0);
    serr_n = 0;
    serr_c = -1;
    send(0, 0, 1'b0, fc, lc);
    idle(70);
    chk("t7 sync_err pulses", serr_n, 1);
    chk("t7 sync_err cycle", serr_c, fc);
    chk("t7 burst length", cap_n[0], 64);
    chk("t7 bit8", int'(cap[0][8]), 1);
    chk("t7 ones", ones(0, 0, 63), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
